// File: rtl/bit4_3_multiplier_pkg.sv
// Shared widths and legal LATENCY bounds for the 3x4 array multiplier.
package bit4_3_multiplier_pkg;
  localparam int A_W     = 3;
  localparam int B_W     = 4;
  localparam int P_W     = A_W + B_W;
  localparam int ROW_W   = A_W + 1;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
endpackage

// File: rtl/bit4_3_multiplier_fa_cell.sv
// One-bit full adder used at every position of the multiplier adder array.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/bit4_3_multiplier.sv
// Registered 3x4 unsigned array multiplier, LATENCY 1 or 2 cycles.
// Define BIT4_3_MULTIPLIER_ZERO_FLAG_EN to add the registered c_zero output.
module bit4_3_multiplier
  import bit4_3_multiplier_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic in_valid,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic out_valid
`ifdef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
  ,
  output logic c_zero
`endif
);

  logic [A_W-1:0]   a_vec;
  logic [B_W-1:0]   b_vec;
  logic [A_W-1:0]   pp     [B_W];
  // row[j] is the running sum of partial-product rows 0..j, weights j..j+A_W
  logic [ROW_W-1:0] row    [B_W];
  logic [A_W-1:0]   row_hi [1:B_W-1];
  logic [A_W-1:0]   pp_in  [1:B_W-1];
  logic [ROW_W-1:0] carry  [1:B_W-1];
  logic [1:0]       lo_bits;
  logic             v_last;
  logic [P_W-1:0]   product_next;
  logic [P_W-1:0]   c_reg;
  logic             out_valid_reg;

  assign a_vec = {a2, a1, a0};
  assign b_vec = {b3, b2, b1, b0};

  genvar gi, gj;
  generate
    for (gi = 0; gi < B_W; gi++) begin : g_pp
      assign pp[gi] = a_vec & {A_W{b_vec[gi]}};
    end

    assign row[0] = {1'b0, pp[0]};

    for (gi = 1; gi < B_W; gi++) begin : g_row
      assign carry[gi][0] = 1'b0;
      for (gj = 0; gj < A_W; gj++) begin : g_cell
        fa_cell u_fa (
          .x    (pp_in[gi][gj]),
          .y    (row_hi[gi][gj]),
          .cin  (carry[gi][gj]),
          .s    (row[gi][gj]),
          .cout (carry[gi][gj+1])
        );
      end
      assign row[gi][A_W] = carry[gi][A_W];
    end

    assign row_hi[1] = row[0][ROW_W-1:1];
    assign pp_in[1]  = pp[1];
    assign row_hi[3] = row[2][ROW_W-1:1];

    if (LATENCY >= LAT_MAX) begin : g_stage
      // Cut after the first adder row; remaining rows see only registered data.
      logic [A_W-1:0] row1_hi_reg;
      logic [1:0]     lo_reg;
      logic [A_W-1:0] pp2_reg;
      logic [A_W-1:0] pp3_reg;
      logic           v1_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          row1_hi_reg <= '0;
          lo_reg      <= '0;
          pp2_reg     <= '0;
          pp3_reg     <= '0;
          v1_reg      <= 1'b0;
        end else begin
          v1_reg <= in_valid;
          if (in_valid) begin
            row1_hi_reg <= row[1][ROW_W-1:1];
            lo_reg      <= {row[1][0], row[0][0]};
            pp2_reg     <= pp[2];
            pp3_reg     <= pp[3];
          end
        end
      end

      assign row_hi[2] = row1_hi_reg;
      assign pp_in[2]  = pp2_reg;
      assign pp_in[3]  = pp3_reg;
      assign lo_bits   = lo_reg;
      assign v_last    = v1_reg;
    end else begin : g_no_stage
      assign row_hi[2] = row[1][ROW_W-1:1];
      assign pp_in[2]  = pp[2];
      assign pp_in[3]  = pp[3];
      assign lo_bits   = {row[1][0], row[0][0]};
      assign v_last    = in_valid;
    end
  endgenerate

  assign product_next = {row[B_W-1], row[2][0], lo_bits};

  // C only loads on a valid result, so it holds through idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= v_last;
      if (v_last) c_reg <= product_next;
    end
  end

  assign {c6, c5, c4, c3, c2, c1, c0} = c_reg;
  assign out_valid = out_valid_reg;

`ifdef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
  logic c_zero_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_zero_reg <= 1'b1;
    end else if (v_last) begin
      c_zero_reg <= (product_next == '0);
    end
  end

  assign c_zero = c_zero_reg;
`endif

endmodule

// File: tb/tb_bit4_3_multiplier.sv
// Bench driving LATENCY=1 and LATENCY=2 instances from one stimulus stream,
// each checked against an ideal delayed-product reference.
module tb_bit4_3_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid;
  logic a0, a1, a2, b0, b1, b2, b3;
  logic [6:0] c_l1, c_l2;
  logic ov_l1, ov_l2;
  logic cz_l1, cz_l2;

  bit4_3_multiplier #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_valid(in_valid),
    .c0(c_l1[0]), .c1(c_l1[1]), .c2(c_l1[2]), .c3(c_l1[3]),
    .c4(c_l1[4]), .c5(c_l1[5]), .c6(c_l1[6]),
    .out_valid(ov_l1)
`ifdef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
    , .c_zero(cz_l1)
`endif
  );

  bit4_3_multiplier #(.LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_valid(in_valid),
    .c0(c_l2[0]), .c1(c_l2[1]), .c2(c_l2[2]), .c3(c_l2[3]),
    .c4(c_l2[4]), .c5(c_l2[5]), .c6(c_l2[6]),
    .out_valid(ov_l2)
`ifdef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
    , .c_zero(cz_l2)
`endif
  );

`ifndef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
  assign cz_l1 = 1'b0;
  assign cz_l2 = 1'b0;
`endif

  typedef struct {
    logic [2:0] a;
    logic [3:0] b;
    logic       v;
    logic       rst;
    logic [6:0] exp_c;
  } vec_t;

  vec_t tbl [16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic       hv [0:1023];
  logic [6:0] hc [0:1023];
  logic [6:0] mc [2];
  logic       mv [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after posedge, compare both instances.
  task automatic step(input logic [2:0] a, input logic [3:0] b, input logic v,
                      input logic rst, input logic [6:0] exp_c);
    @(negedge clk);
    {a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    in_valid = v;
    rst_n = ~rst;
    @(posedge clk);
    #1;
    hv[cyc] = v && !rst;
    hc[cyc] = exp_c;
    if (rst) begin
      if (cyc > 0) hv[cyc-1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mc[k] = '0;
        mv[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = cyc - k;
        mv[k] = (idx >= 0) && hv[idx];
        if (mv[k]) mc[k] = hc[idx];
      end
    end
    $display("cyc %0d a=%0d b=%0d v=%0d rst=%0d | L1 c=%0d ov=%0d | L2 c=%0d ov=%0d",
             cyc, a, b, v, rst, c_l1, ov_l1, c_l2, ov_l2);
    chk("L1 product", {1'b0, c_l1}, {1'b0, mc[0]});
    chk("L1 out_valid", {7'd0, ov_l1}, {7'd0, mv[0]});
    chk("L2 product", {1'b0, c_l2}, {1'b0, mc[1]});
    chk("L2 out_valid", {7'd0, ov_l2}, {7'd0, mv[1]});
`ifdef BIT4_3_MULTIPLIER_ZERO_FLAG_EN
    chk("L1 c_zero", {7'd0, cz_l1}, {7'd0, (mc[0] == 7'd0)});
    chk("L2 c_zero", {7'd0, cz_l2}, {7'd0, (mc[1] == 7'd0)});
`endif
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    {a2, a1, a0} = 3'd0;
    {b3, b2, b1, b0} = 4'd0;
    mc[0] = '0; mc[1] = '0;
    mv[0] = 1'b0; mv[1] = 1'b0;

    //          a  b   v  rst exp
    tbl[0]  = '{3'd0, 4'd0,  1'b1, 1'b0, 7'd0};
    tbl[1]  = '{3'd6, 4'd3,  1'b1, 1'b0, 7'd18};
    tbl[2]  = '{3'd7, 4'd15, 1'b1, 1'b0, 7'd105};
    tbl[3]  = '{3'd5, 4'd9,  1'b1, 1'b0, 7'd45};
    tbl[4]  = '{3'd2, 4'd5,  1'b0, 1'b0, 7'd0};
    tbl[5]  = '{3'd7, 4'd15, 1'b0, 1'b0, 7'd0};
    tbl[6]  = '{3'd1, 4'd1,  1'b0, 1'b0, 7'd0};
    tbl[7]  = '{3'd0, 4'd0,  1'b0, 1'b0, 7'd0};
    tbl[8]  = '{3'd4, 4'd13, 1'b1, 1'b0, 7'd52};
    tbl[9]  = '{3'd7, 4'd1,  1'b1, 1'b0, 7'd7};
    tbl[10] = '{3'd1, 4'd8,  1'b1, 1'b0, 7'd8};
    tbl[11] = '{3'd3, 4'd3,  1'b0, 1'b0, 7'd0};
    tbl[12] = '{3'd0, 4'd9,  1'b1, 1'b0, 7'd0};
    tbl[13] = '{3'd6, 4'd6,  1'b0, 1'b0, 7'd0};
    tbl[14] = '{3'd5, 4'd11, 1'b1, 1'b0, 7'd55};
    tbl[15] = '{3'd2, 4'd2,  1'b0, 1'b0, 7'd0};

    // Reset state
    step(3'd0, 4'd0, 1'b0, 1'b1, 7'd0);
    step(3'd0, 4'd0, 1'b0, 1'b1, 7'd0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].rst, tbl[i].exp_c);
    end
    step(3'd0, 4'd0, 1'b0, 1'b0, 7'd0);

    // Accept 3*4, then reset on the next edge: product 12 must never appear
    step(3'd3, 4'd4, 1'b1, 1'b0, 7'd12);
    step(3'd7, 4'd7, 1'b1, 1'b1, 7'd0);
    step(3'd1, 4'd2, 1'b0, 1'b0, 7'd0);
    step(3'd3, 4'd4, 1'b0, 1'b0, 7'd0);
    step(3'd0, 4'd0, 1'b0, 1'b0, 7'd0);

    // First input right after reset release is processed normally
    step(3'd3, 4'd4, 1'b0, 1'b1, 7'd0);
    step(3'd2, 4'd3, 1'b1, 1'b0, 7'd6);
    step(3'd0, 4'd0, 1'b0, 1'b0, 7'd0);
    step(3'd5, 4'd5, 1'b0, 1'b0, 7'd0);

    // Exhaustive back-to-back sweep
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 16; b++) begin
        step(3'(a), 4'(b), 1'b1, 1'b0, 7'(a * b));
      end
    end
    step(3'd1, 4'd1, 1'b0, 1'b0, 7'd0);
    step(3'd6, 4'd2, 1'b0, 1'b0, 7'd0);
    step(3'd0, 4'd0, 1'b0, 1'b0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit4_3_multiplier.md
BIT4_3_MULTIPLIER -- requirements
Module: bit4_3_multiplier

Interface
REQ-001 Parameters SHALL be:
- LATENCY, default 1, clock cycles from a sampled input to its registered product; legal values 1 or 2.
REQ-002 The block SHALL use one clock. Reset SHALL be synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- a0,a1,a2  input  1 each  3-bit unsigned multiplicand A; a0 is the LSB.
- b0,b1,b2,b3  input  1 each  4-bit unsigned multiplier B; b0 is the LSB.
- in_valid  input  1  qualifies A and B in the current cycle.
- c0..c6  output  1 each  7-bit unsigned product C; c0 is the LSB.
- out_valid  output  1  C holds a new product this cycle.
- c_zero  output  1  product is zero; present only with the macro in REQ-013.

Function
REQ-004 C SHALL equal A*B exactly as unsigned values; 7 bits always suffice (max 7*15=105), so no overflow or truncation.
REQ-005 Product logic SHALL be an array multiplier:
- twelve AND partial products a_i&b_j, weight i+j;
- summed with ripple rows of full-adder cells;
- no behavioural "*" operator.
REQ-006 On a rising clk edge with rst_n=1 and in_valid=1, A and B SHALL be sampled.
- Their product SHALL appear on c0..c6 exactly LATENCY cycles later, with out_valid=1 in that cycle.
REQ-007 out_valid SHALL be in_valid delayed by LATENCY cycles.
- Back-to-back valid inputs SHALL give back-to-back valid outputs; throughput is one product per cycle.
REQ-008 When no valid result emerges from the pipeline:
- c0..c6 SHALL hold their last valid value;
- out_valid SHALL be 0.
REQ-009 With LATENCY=2, the partial-product/first-adder-row result SHALL be registered in an internal stage.
- The remaining adder rows SHALL be computed after that stage.
REQ-010 Inputs changing while in_valid=0 SHALL have no effect on any output.

Reset
REQ-011 While rst_n=0 at a rising clk edge, the block SHALL clear:
- c0..c6 to 0;
- out_valid to 0;
- c_zero (if present) to 1;
- all internal pipeline and valid registers.
REQ-012 Reset asserted mid-operation SHALL discard all in-flight products; none SHALL emerge after reset releases.
- The first input sampled on the edge after release SHALL be processed normally.

Configuration
REQ-013 Macro BIT4_3_MULTIPLIER_ZERO_FLAG_EN SHALL control the c_zero port:
- defined: c_zero SHALL exist, registered alongside C, and SHALL be 1 exactly when C=0;
- undefined: the port and its logic SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-014 Package bit4_3_multiplier_pkg SHALL hold:
- A_W=3, B_W=4, P_W=7;
- the legal LATENCY bounds.
REQ-015 One sub-module, fa_cell, SHALL be used:
- inputs x, y, cin; outputs s, cout;
- instantiated for every adder position in the array.

Verification
REQ-016 A=0, B=0, in_valid=1 -> after LATENCY cycles C=0000000, out_valid=1, c_zero=1.
REQ-017 a0=0,a1=1,a2=1 (A=6) and b0=1,b1=1,b2=0,b3=0 (B=3), in_valid=1 -> C=18, i.e. c1=1, c4=1, all other bits 0.
REQ-018 A=7, B=15 -> C=105 (c6..c0=1101001); exhaustive sweep of all 128 A/B pairs back-to-back -> every C equals A*B with out_valid high on consecutive cycles.
REQ-019 Valid A=5, B=9, then in_valid=0 with inputs toggling -> C stays 45, out_valid=0.
REQ-020 Valid A=3, B=4 accepted, rst_n=0 on the next edge -> C=0 and out_valid=0, and no product 12 ever appears afterwards.
REQ-021 Repeat REQ-016 to REQ-020 for LATENCY=1 and LATENCY=2, each with and without BIT4_3_MULTIPLIER_ZERO_FLAG_EN.
